div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Execute-stage front end for the long-division divider; sits directly upstream of it. Accepts RV32M DIV/DIVU/REM/REMU requests from the execute stage and drives the divider's en/a/b/is_signed interface. Holds operands stable for the whole operation and returns the selected quotient or remainder through a registered response. A one-entry result cache lets a DIV/REM pair on identical operands complete without a second 34-cycle division.

Parameters:
CACHE_EN, 1, 1 = one-entry quotient/remainder cache enabled; 0 = every request goes to the divider.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; the divider's nrst is driven from ~rst, so both reset on the same edge
req_valid  in  1  divide request present
req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
req_a  in  32  rs1 (dividend)
req_b  in  32  rs2 (divisor)
req_ready  out  1  request accepted this cycle
flush  in  1  pipeline flush; cancels the in-flight request
resp_valid  out  1  one-cycle result pulse
resp_data  out  32  quotient or remainder
resp_div_by_zero  out  1  divisor was zero
resp_overflow  out  1  signed overflow (0x80000000 / -1)
div_en  out  1  to divider en
div_is_signed  out  1  to divider is_signed
div_a  out  32  to divider a
div_b  out  32  to divider b
div_q  in  32  from divider q
div_r  in  32  from divider r
div_ready  in  1  from divider ready
div_by_zero  in  1  from divider div_by_zero
div_overflow  in  1  from divider overflow

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready, resp_valid, resp_data, both resp flags, div_en: all 0.
  - Operand registers: 0. Cache invalid.
- Decode:
  - is_signed = ~req_op[0].
  - Remainder select = req_op[1].
- Operand hold: div_a, div_b and div_is_signed come only from the operand registers. They stay constant from ISSUE until the divider's ready pulse, because the divider's output sign correction reads them combinationally.
- req_ready = (state == IDLE). A request is accepted on (req_valid & req_ready & ~flush). With flush high in the same cycle, the request is dropped.
- State machine:
  - IDLE, on accept: latch op/a/b.
    - Cache hit (CACHE_EN, cache valid, same a, b, is_signed): go to RESP using cached q/r/flags.
    - Otherwise: go to ISSUE.
  - ISSUE: div_en = 1 for exactly this one cycle. Next state is WAIT, or DRAIN if flush.
  - WAIT: div_en = 0.
    - On div_ready: capture div_q, div_r, div_by_zero, div_overflow into the cache and go to RESP.
    - On flush (with no div_ready): go to DRAIN.
    - If flush and div_ready occur together: DRAIN wins and the cache is not written.
  - DRAIN: wait for div_ready, discard the result, go to IDLE. No response is produced.
  - RESP:
    - resp_valid = ~flush.
    - resp_data = remainder ? r : q.
    - Flags are passed through from the capture.
    - Next state is IDLE.
- Response registers: resp_data and flags hold their value until the next RESP. resp_valid is high only in RESP.
- Latency, with the request accepted at cycle T:
  - Cache hit: resp_valid at T+1.
  - Divide by zero or signed overflow: divider ready at T+2, resp_valid at T+3.
  - Normal: divider runs 32 DIVIDE cycles, ready at T+35, resp_valid at T+36.
- Corner values come from the divider and are forwarded unmodified:
  - x/0: q = 0xFFFFFFFF, r = x.
  - Signed 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0.
- Cache:
  - Written only on a non-flushed div_ready.
  - Invalidated by rst or by any flush.
  - Unsigned and signed entries never alias, because is_signed is part of the tag.
- Reset mid-operation: both blocks return to IDLE on the same edge. No resp_valid is produced, and the next request starts normally.

Test Plan:
1. DIVU a=100, b=7 accepted at T -> div_en high only at T+1; resp_valid at T+36 with resp_data=14, flags 0.
2. DIV a=0xFFFFFFF9 (-7), b=2, then REM with the same operands -> first resp 0xFFFFFFFD (-3) at T+36; second resp 0xFFFFFFFF (-1) one cycle after accept, with div_en never asserted.
3. DIV 5/0, then REMU 5/0 -> first resp 0xFFFFFFFF at T+3 with resp_div_by_zero=1; second resp 5 with resp_div_by_zero=1.
4. DIV 0x80000000/0xFFFFFFFF -> resp 0x80000000 at T+3 with resp_overflow=1; REM on the same operands -> 0.
5. DIVU 100/7 with flush at T+10 -> no resp_valid; req_ready low until one cycle after the divider's ready (T+35); next DIVU 9/3 returns 3 at its own T+36, not a cache hit.
6. rst asserted at T+20 of a normal divide -> all outputs 0 the next cycle, no resp_valid; a following DIVU 8/2 returns 4 at T+36.

Source files
------------

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/response bundle between execute stage and div_sequencer
//
// Purpose: groups the divide request handshake and the registered response.
//   master : execute stage (drives the request, receives the response)
//   slave  : div_sequencer (accepts the request, drives the response)
// Signals:
//   req_valid        request present
//   req_op[1:0]      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a, req_b     dividend / divisor
//   req_ready        request accepted this cycle
//   resp_valid       one-cycle result pulse
//   resp_data        quotient or remainder
//   resp_div_by_zero divisor was zero
//   resp_overflow    signed overflow (0x80000000 / -1)
interface div_sequencer_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_div_by_zero;
  logic        resp_overflow;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, resp_valid, resp_data, resp_div_by_zero, resp_overflow
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, resp_valid, resp_data, resp_div_by_zero, resp_overflow
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - execute-stage front end for the long-division divider
//
// Purpose: accepts DIV/DIVU/REM/REMU requests, drives the divider with operands
// held stable for the whole operation, and returns the selected quotient or
// remainder through registered response flops. A one-entry cache lets a DIV/REM
// pair on identical operands finish without a second division.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_if (slave)  request handshake and response (see div_sequencer_if)
//   flush           pipeline flush, cancels the in-flight request
//   div_en          one-cycle start pulse to the divider
//   div_is_signed   signed operation, held from ISSUE until div_ready
//   div_a, div_b    dividend / divisor, held from ISSUE until div_ready
//   div_q, div_r    divider quotient / remainder
//   div_ready       divider result pulse
//   div_by_zero     divider flag: divisor was zero
//   div_overflow    divider flag: signed overflow
module div_sequencer #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  div_sequencer_if.slave     req_if,
  input  logic               flush,
  output logic               div_en,
  output logic               div_is_signed,
  output logic [31:0]        div_a,
  output logic [31:0]        div_b,
  input  logic [31:0]        div_q,
  input  logic [31:0]        div_r,
  input  logic               div_ready,
  input  logic               div_by_zero,
  input  logic               div_overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e      state_q, state_d;

  // Operand registers: the only source of the divider inputs.
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_signed_q, op_signed_d;
  logic        op_rem_q, op_rem_d;

  // One-entry result cache; is_signed is part of the tag.
  logic        cache_vld_q, cache_vld_d;
  logic [31:0] cache_a_q, cache_a_d;
  logic [31:0] cache_b_q, cache_b_d;
  logic        cache_signed_q, cache_signed_d;
  logic [31:0] cache_quo_q, cache_quo_d;
  logic [31:0] cache_rem_q, cache_rem_d;
  logic        cache_dz_q, cache_dz_d;
  logic        cache_ov_q, cache_ov_d;

  // Response registers hold their value until the next RESP.
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_dz_q, resp_dz_d;
  logic        resp_ov_q, resp_ov_d;

  logic        accept;
  logic        cache_hit;
  logic        capture;

  assign accept    = req_if.req_valid & (state_q == S_IDLE) & ~flush;
  assign cache_hit = CACHE_EN & cache_vld_q
                   & (cache_a_q == req_if.req_a)
                   & (cache_b_q == req_if.req_b)
                   & (cache_signed_q == ~req_if.req_op[0]);
  // A flush coinciding with div_ready wins: nothing is captured.
  assign capture   = (state_q == S_WAIT) & div_ready & ~flush;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_signed_q    <= 1'b0;
      op_rem_q       <= 1'b0;
      cache_vld_q    <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
      cache_dz_q     <= 1'b0;
      cache_ov_q     <= 1'b0;
      resp_data_q    <= '0;
      resp_dz_q      <= 1'b0;
      resp_ov_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_signed_q    <= op_signed_d;
      op_rem_q       <= op_rem_d;
      cache_vld_q    <= cache_vld_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_signed_q <= cache_signed_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
      cache_dz_q     <= cache_dz_d;
      cache_ov_q     <= cache_ov_d;
      resp_data_q    <= resp_data_d;
      resp_dz_q      <= resp_dz_d;
      resp_ov_q      <= resp_ov_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = cache_hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)          state_d = S_DRAIN;
        else if (div_ready) state_d = S_RESP;
      end
      // The divider cannot be aborted, so its late result is swallowed here.
      S_DRAIN: if (div_ready) state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_signed_d    = op_signed_q;
    op_rem_d       = op_rem_q;
    cache_vld_d    = cache_vld_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_signed_d = cache_signed_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    cache_dz_d     = cache_dz_q;
    cache_ov_d     = cache_ov_q;
    resp_data_d    = resp_data_q;
    resp_dz_d      = resp_dz_q;
    resp_ov_d      = resp_ov_q;

    if (accept) begin
      op_a_d      = req_if.req_a;
      op_b_d      = req_if.req_b;
      op_signed_d = ~req_if.req_op[0];
      op_rem_d    = req_if.req_op[1];
      if (cache_hit) begin
        resp_data_d = req_if.req_op[1] ? cache_rem_q : cache_quo_q;
        resp_dz_d   = cache_dz_q;
        resp_ov_d   = cache_ov_q;
      end
    end

    if (capture) begin
      resp_data_d    = op_rem_q ? div_r : div_q;
      resp_dz_d      = div_by_zero;
      resp_ov_d      = div_overflow;
      cache_vld_d    = 1'b1;
      cache_a_d      = op_a_q;
      cache_b_d      = op_b_q;
      cache_signed_d = op_signed_q;
      cache_quo_d    = div_q;
      cache_rem_d    = div_r;
      cache_dz_d     = div_by_zero;
      cache_ov_d     = div_overflow;
    end

    if (flush) cache_vld_d = 1'b0;
  end

  // Outputs
  always_comb begin
    req_if.req_ready        = (state_q == S_IDLE) & ~rst;
    req_if.resp_valid       = (state_q == S_RESP) & ~flush;
    req_if.resp_data        = resp_data_q;
    req_if.resp_div_by_zero = resp_dz_q;
    req_if.resp_overflow    = resp_ov_q;
    div_en                  = (state_q == S_ISSUE);
    div_is_signed           = op_signed_q;
    div_a                   = op_a_q;
    div_b                   = op_b_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed bench for div_sequencer with a behavioural divider
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        div_en, div_is_signed;
  logic [31:0] div_a, div_b;
  logic [31:0] div_q, div_r;
  logic        div_ready = 1'b0;
  logic        div_by_zero, div_overflow;
  int          errors = 0;
  int          checks = 0;

  div_sequencer_if sif ();

  div_sequencer #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_if(sif), .flush(flush),
    .div_en(div_en), .div_is_signed(div_is_signed), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_ready(div_ready),
    .div_by_zero(div_by_zero), .div_overflow(div_overflow)
  );

  always #5 clk = ~clk;

  // Divider model: ready one cycle after en for corner cases, 34 cycles after otherwise.
  logic [5:0]  dcnt = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_s = 1'b0;
  logic signed [31:0] sa, sb;
  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (rst) dcnt <= '0;
    else if (div_en) begin
      m_a <= div_a; m_b <= div_b; m_s <= div_is_signed;
      if (div_b == 32'd0 || (div_is_signed && div_a == 32'h8000_0000 && div_b == 32'hFFFF_FFFF))
        div_ready <= 1'b1;
      else
        dcnt <= 6'd33;
    end else if (dcnt != 6'd0) begin
      dcnt <= dcnt - 6'd1;
      if (dcnt == 6'd1) div_ready <= 1'b1;
    end
  end
  always_comb begin
    sa = m_a; sb = m_b;
    div_by_zero  = (m_b == 32'd0);
    div_overflow = m_s && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF;
    if (div_by_zero)       begin div_q = 32'hFFFF_FFFF; div_r = m_a; end
    else if (div_overflow) begin div_q = 32'h8000_0000; div_r = 32'd0; end
    else if (m_s)          begin div_q = sa / sb; div_r = sa % sb; end
    else                   begin div_q = m_a / m_b; div_r = m_a % m_b; end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one request (DUT idle) and waits up to 60 cycles for the response.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] data, output logic dz,
                        output logic ov, output int en_cnt, output int en_first);
    lat = 0; data = '0; dz = 1'b0; ov = 1'b0; en_cnt = 0; en_first = 0;
    @(negedge clk);
    sif.req_valid = 1'b1; sif.req_op = op; sif.req_a = a; sif.req_b = b;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) sif.req_valid = 1'b0;
      if (div_en) begin en_cnt++; if (en_first == 0) en_first = n; end
      if (sif.resp_valid) begin
        lat = n; data = sif.resp_data; dz = sif.resp_div_by_zero; ov = sif.resp_overflow;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sif.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", sif.req_ready); end
    checks++; if (sif.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", sif.resp_valid); end
    checks++; if (div_en !== 1'b0) begin errors++; $display("FAIL rst_div_en: got %b expected 0", div_en); end
    checks++; if ({sif.resp_data, sif.resp_div_by_zero, sif.resp_overflow} !== 34'd0) begin errors++; $display("FAIL rst_resp: got %h/%b/%b expected 0", sif.resp_data, sif.resp_div_by_zero, sif.resp_overflow); end
    checks++; if ({div_a, div_b} !== 64'd0) begin errors++; $display("FAIL rst_operands: got %h/%h expected 0", div_a, div_b); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sif.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", sif.req_ready); end
  endtask

  task automatic test_divu_basic;
    int lat, ec, ef; logic [31:0] d; logic dz, ov;
    do_req(2'b01, 32'd100, 32'd7, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 36) begin errors++; $display("FAIL divu_latency: got %0d expected 36", lat); end
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_data: got %h expected 0000000e", d); end
    checks++; if ({dz, ov} !== 2'b00) begin errors++; $display("FAIL divu_flags: got %b%b expected 00", dz, ov); end
    checks++; if (ec !== 1 || ef !== 1) begin errors++; $display("FAIL divu_en_pulse: got count %0d first %0d expected 1/1", ec, ef); end
    @(negedge clk);
    checks++; if (sif.resp_valid !== 1'b0 || sif.resp_data !== 32'd14) begin errors++; $display("FAIL divu_resp_hold: got valid %b data %h expected 0/0000000e", sif.resp_valid, sif.resp_data); end
  endtask

  task automatic test_signed_cache;
    int lat, ec, ef; logic [31:0] d; logic dz, ov;
    do_req(2'b00, 32'hFFFF_FFF9, 32'd2, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 36 || d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got lat %0d data %h expected 36/fffffffd", lat, d); end
    do_req(2'b10, 32'hFFFF_FFF9, 32'd2, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 1 || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_hit: got lat %0d data %h expected 1/ffffffff", lat, d); end
    checks++; if (ec !== 0) begin errors++; $display("FAIL rem_hit_no_en: got %0d div_en pulses expected 0", ec); end
  endtask

  task automatic test_div_by_zero;
    int lat, ec, ef; logic [31:0] d; logic dz, ov;
    do_req(2'b00, 32'd5, 32'd0, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 3 || d !== 32'hFFFF_FFFF || dz !== 1'b1) begin errors++; $display("FAIL div_zero: got lat %0d data %h dz %b expected 3/ffffffff/1", lat, d, dz); end
    // REMU carries a different signedness tag, so it goes back to the divider.
    do_req(2'b11, 32'd5, 32'd0, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 3 || d !== 32'd5 || dz !== 1'b1) begin errors++; $display("FAIL remu_zero: got lat %0d data %h dz %b expected 3/00000005/1", lat, d, dz); end
  endtask

  task automatic test_overflow;
    int lat, ec, ef; logic [31:0] d; logic dz, ov;
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 3 || d !== 32'h8000_0000 || ov !== 1'b1 || dz !== 1'b0) begin errors++; $display("FAIL div_ovf: got lat %0d data %h ov %b dz %b expected 3/80000000/1/0", lat, d, ov, dz); end
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 1 || d !== 32'd0 || ov !== 1'b1) begin errors++; $display("FAIL rem_ovf_hit: got lat %0d data %h ov %b expected 1/00000000/1", lat, d, ov); end
  endtask

  task automatic test_flush_inflight;
    int lat, ec, ef, rdy_n, seen; logic [31:0] d; logic dz, ov;
    rdy_n = 0; seen = 0;
    @(negedge clk);
    sif.req_valid = 1'b1; sif.req_op = 2'b01; sif.req_a = 32'd100; sif.req_b = 32'd7;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) sif.req_valid = 1'b0;
      if (sif.resp_valid) seen++;
      if (sif.req_ready && rdy_n == 0) rdy_n = n;
      flush = (n == 10);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_resp: got %0d resp_valid cycles expected 0", seen); end
    checks++; if (rdy_n !== 36) begin errors++; $display("FAIL flush_ready_return: got cycle %0d expected 36", rdy_n); end
    // The earlier overflow entry must have been invalidated by the flush.
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 3 || ec !== 1) begin errors++; $display("FAIL flush_invalidates: got lat %0d en %0d expected 3/1", lat, ec); end
    do_req(2'b01, 32'd9, 32'd3, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 36 || d !== 32'd3) begin errors++; $display("FAIL after_flush_divu: got lat %0d data %h expected 36/00000003", lat, d); end
  endtask

  task automatic test_reset_midop;
    int lat, ec, ef, seen; logic [31:0] d; logic dz, ov;
    seen = 0;
    @(negedge clk);
    sif.req_valid = 1'b1; sif.req_op = 2'b01; sif.req_a = 32'd100; sif.req_b = 32'd7;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) sif.req_valid = 1'b0;
      if (n == 21) begin
        checks++;
        if ({sif.req_ready, sif.resp_valid, div_en, sif.resp_data, sif.resp_div_by_zero, sif.resp_overflow, div_a, div_b} !== 101'd0) begin
          errors++; $display("FAIL midop_reset_outputs: got rdy %b vld %b en %b data %h a %h b %h expected all 0", sif.req_ready, sif.resp_valid, div_en, sif.resp_data, div_a, div_b);
        end
        rst = 1'b0;
      end
      if (sif.resp_valid) seen++;
      if (n == 20) rst = 1'b1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midop_no_resp: got %0d resp_valid cycles expected 0", seen); end
    // Reset also clears the cache entry left by 9/3.
    do_req(2'b01, 32'd9, 32'd3, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 36 || d !== 32'd3) begin errors++; $display("FAIL reset_invalidates: got lat %0d data %h expected 36/00000003", lat, d); end
    do_req(2'b01, 32'd8, 32'd2, lat, d, dz, ov, ec, ef);
    checks++; if (lat !== 36 || d !== 32'd4) begin errors++; $display("FAIL after_reset_divu: got lat %0d data %h expected 36/00000004", lat, d); end
  endtask

  task automatic test_flush_on_accept;
    int ec, not_ready;
    ec = 0; not_ready = 0;
    @(negedge clk);
    sif.req_valid = 1'b1; sif.req_op = 2'b01; sif.req_a = 32'd50; sif.req_b = 32'd5;
    flush = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      sif.req_valid = 1'b0; flush = 1'b0;
      if (div_en) ec++;
      if (!sif.req_ready) not_ready++;
    end
    checks++; if (ec !== 0 || not_ready !== 0) begin errors++; $display("FAIL flush_drops_req: got en %0d busy %0d expected 0/0", ec, not_ready); end
  endtask

  initial begin
    sif.req_valid = 1'b0; sif.req_op = 2'b00; sif.req_a = '0; sif.req_b = '0;
    test_reset();
    test_divu_basic();
    test_signed_cache();
    test_div_by_zero();
    test_overflow();
    test_flush_inflight();
    test_reset_midop();
    test_flush_on_accept();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
